// File: rtl/pipe_stage_skid_reg.sv
// ============================================================================
// Module   : pipe_stage_skid_reg
// Brief    : Pipeline stage register with valid/ready handshake, two-entry
//            skid buffer, synchronous flush and occupancy count.
//            Optional macro PIPE_SKID_TRISTATE_EN: cs tri-states Q and masks
//            out_valid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid_reg #(
    parameter int                  NrOfBits   = 32,
    parameter logic [NrOfBits-1:0] ResetValue = '0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic                Flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NrOfBits-1:0] D,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NrOfBits-1:0] Q,
    input  logic                cs,
    output logic [1:0]          Count
);

    logic [NrOfBits-1:0] r_main_data;
    logic                r_main_valid;
    logic [NrOfBits-1:0] r_skid_data;
    logic                r_skid_valid;

    logic w_advance;
    logic w_push;
    logic w_pop;
    logic w_out_valid;

    assign w_advance = ClockEnable & Tick;
    // in_ready comes straight from a flop, so out_ready never reaches it combinationally
    assign in_ready  = ~r_skid_valid;
    assign w_push    = w_advance & in_valid & ~r_skid_valid;
    assign w_pop     = w_advance & w_out_valid & out_ready;
    assign Count     = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_main_data  <= ResetValue;
            r_main_valid <= 1'b0;
            r_skid_data  <= ResetValue;
            r_skid_valid <= 1'b0;
        end else if (w_advance && Flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_pop && r_skid_valid) begin
            r_main_data  <= r_skid_data;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
        end else if (w_push && (!r_main_valid || w_pop)) begin
            r_main_data  <= D;
            r_main_valid <= 1'b1;
        end else if (w_push) begin
            r_skid_data  <= D;
            r_skid_valid <= 1'b1;
        end else if (w_pop) begin
            r_main_valid <= 1'b0;
        end
    end

`ifdef PIPE_SKID_TRISTATE_EN
    // Downstream sees no valid while deselected, so nothing is popped then
    assign Q           = cs ? {NrOfBits{1'bz}} : r_main_data;
    assign w_out_valid = r_main_valid & ~cs;
`else
    logic w_unused_cs;
    assign w_unused_cs = cs;
    assign Q           = r_main_data;
    assign w_out_valid = r_main_valid;
`endif

    assign out_valid = w_out_valid;

endmodule

`default_nettype wire

// File: doc/pipe_stage_skid_reg.md
# pipe_stage_skid_reg

Parametrised pipeline stage register for the CPU datapath. It is the next generation of the per-stage data flip-flops (e.g. the writeback memory-data register). It replaces the bare enable-gated register with a valid/ready handshake, a two-entry skid buffer for stall absorption, a synchronous flush for branch/exception squash, and an occupancy count. It sits between any two pipeline stages and gives full throughput with registered ready and valid paths.

## Interface
- NrOfBits, 32, data width (1..64)
- ResetValue, 0, value loaded into both data entries on Reset

- Clock  in  1  stage clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high; clears state immediately
- ClockEnable  in  1  global clock enable
- Tick  in  1  clock-gating tick; advance = ClockEnable & Tick
- Flush  in  1  synchronous squash, sampled only on advance
- in_valid  in  1  upstream data valid
- in_ready  out  1  stage can accept; registered
- D  in  NrOfBits  upstream data
- out_valid  out  1  Q holds a valid item; registered
- out_ready  in  1  downstream accepts
- Q  out  NrOfBits  head data (main entry)
- cs  in  1  output disable, active-high (see Configuration)
- Count  out  2  occupancy, 0..2

## Operation
- State: main entry (data + valid) and skid entry (data + valid). out_valid = main valid. in_ready = ~skid valid. Count = main valid + skid valid.
- Reset (async): both valids 0, both data = ResetValue. Outputs: out_valid=0, in_ready=1, Count=0, Q=ResetValue.
- No advance (ClockEnable&Tick=0): all state holds. No transfer occurs even if valid&ready are high.
- Push = advance & in_valid & in_ready. Pop = advance & out_valid & out_ready.
- Flush on advance, highest priority after Reset: both valids cleared, push suppressed, data registers unchanged.
- Otherwise, per rising edge:
  - Pop with skid valid: skid moves to main, skid cleared. No push is possible because in_ready=0.
  - Push when main empty or popping, with skid empty: D goes to main.
  - Push when main full and not popping: D goes to skid.
  - Pop only: main cleared.
- Q always shows main data, including stale data when out_valid=0.
- The consumer must qualify Q with out_valid.
- Count never exceeds 2. A push is impossible at Count=2.

## Timing
- Latency: a push at edge n gives out_valid=1 and Q=D after edge n when the stage was empty.
- Throughput: 1 item/cycle with out_ready held high and advance every cycle.
- Stall absorption: when out_ready drops, the one item already in flight lands in skid; in_ready falls after that edge.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Simultaneous push and pop at Count=1: Count stays 1, main gets D.
- Flush together with push/pop: Flush wins, Count=0 after the edge.
- Reset mid-transfer: items are lost; outputs go to reset values asynchronously, without waiting for a clock.

## Configuration
- PIPE_SKID_TRISTATE_EN defined:
  - Q = cs ? all-Z : main data, for shared-bus hookup.
  - out_valid is forced 0 while cs=1; internal state is unaffected.
- Undefined:
  - cs is ignored and Q is always driven.
  - out_valid = main valid.

## Test plan
- Reset asserted mid-cycle with Count=2 -> out_valid=0, in_ready=1, Count=0, Q=ResetValue without waiting for a clock edge.
- Stream 0x11,0x22,0x33 with out_ready=1, advance every cycle -> Q presents 0x11,0x22,0x33 on consecutive cycles, one cycle after each push; Count=1 throughout.
- Push 0xA1,0xA2 with out_ready=0 -> Count=2, in_ready=0, Q=0xA1. Then out_ready=1 -> Q=0xA2 next cycle, Count=1, in_ready=1.
- Tick=0 with in_valid=1, out_ready=1 for 3 cycles -> no change to Count, Q or valids.
- Count=2, assert Flush with in_valid=1 on advance -> Count=0, out_valid=0, new data not captured.
- With PIPE_SKID_TRISTATE_EN, main=0x5A, cs=1 -> Q=Z, out_valid=0. cs=0 -> Q=0x5A, out_valid=1.
